// File: rtl/iir_sample_driver.sv
// iir_sample_driver: converts offset-binary ADC samples for one biquad pass, then applies
// the band gain to the filter result and emits a saturated offset-binary DAC word.
module iir_sample_driver #(
    parameter int WIDTH   = 29,
    parameter int FRA     = 16,
    parameter int ADC_W   = 12,
    parameter int DAC_W   = 12,
    parameter int GAIN_W  = 8,
    parameter int GFRA    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              adc_valid_i,
    input  logic [ADC_W-1:0]  adc_data_i,
    input  logic [GAIN_W-1:0] gain_i,
    output logic [WIDTH-1:0]  filt_data_o,
    output logic              filt_start_o,
    input  logic              filt_done_i,
    input  logic [WIDTH-1:0]  filt_result_i,
    output logic [DAC_W-1:0]  dac_data_o,
    output logic              dac_valid_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic [7:0]        overrun_cnt_o,
    output logic              timeout_o
);
    localparam int PW = WIDTH + GAIN_W + 1;
    localparam int SH = FRA + GFRA - (DAC_W - 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, SCALE, OUT} state_t;
    state_t state;

    logic [ADC_W-1:0] cur, pend_d;
    logic pend_v, done_q, ovf;
    logic [TW-1:0] timer;
    logic [WIDTH-1:0] conv, res;
    logic [PW-1:0] p;
    logic signed [PW-1:0] ps;
    logic [DAC_W-1:0] sat, dac;

    // Offset binary to two's complement is an MSB flip; then align to the filter's binary point.
    assign conv = {{(WIDTH-ADC_W){~cur[ADC_W-1]}}, ~cur[ADC_W-1], cur[ADC_W-2:0]} << (FRA - ADC_W + 1);
    assign p    = {{(GAIN_W+1){res[WIDTH-1]}}, res} * {{(WIDTH+1){1'b0}}, gain_i};
    assign ps   = $signed(p) >>> SH;
    assign ovf  = !(&ps[PW-1:DAC_W-1]) && |ps[PW-1:DAC_W-1];
    assign sat  = ovf ? {ps[PW-1], {(DAC_W-1){~ps[PW-1]}}} : ps[DAC_W-1:0];
    assign dac  = {~sat[DAC_W-1], sat[DAC_W-2:0]};
    assign busy_o = state != IDLE;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cur           <= '0;
            pend_d        <= '0;
            pend_v        <= 1'b0;
            done_q        <= 1'b0;
            timer         <= '0;
            res           <= '0;
            filt_data_o   <= '0;
            filt_start_o  <= 1'b0;
            dac_data_o    <= {1'b1, {(DAC_W-1){1'b0}}};
            dac_valid_o   <= 1'b0;
            overrun_o     <= 1'b0;
            overrun_cnt_o <= '0;
            timeout_o     <= 1'b0;
        end else begin
            done_q       <= filt_done_i;
            filt_start_o <= 1'b0;
            dac_valid_o  <= 1'b0;
            timer        <= timer + 1'b1;
            if (adc_valid_i && state != IDLE) begin
                if (!pend_v) begin
                    pend_v <= 1'b1;
                    pend_d <= adc_data_i;
                end else begin
                    overrun_o <= 1'b1;
                    if (overrun_cnt_o != 8'hFF) overrun_cnt_o <= overrun_cnt_o + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    // A waiting sample goes first; a fresh strobe then refills the pending slot.
                    if (pend_v) begin
                        cur    <= pend_d;
                        pend_v <= adc_valid_i;
                        pend_d <= adc_data_i;
                        state  <= LOAD;
                    end else if (adc_valid_i) begin
                        cur   <= adc_data_i;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    filt_data_o  <= conv;
                    filt_start_o <= 1'b1;
                    timer        <= '0;
                    state        <= START;
                end
                START: state <= WAIT;
                WAIT: begin
                    if (filt_done_i && !done_q) begin
                        res   <= filt_result_i;
                        state <= SCALE;
                    end else if (timer == T_LAST) begin
                        timeout_o <= 1'b1;
                        state     <= IDLE;
                    end
                end
                SCALE: begin
                    dac_data_o  <= dac;
                    dac_valid_o <= 1'b1;
                    state       <= OUT;
                end
                OUT:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
